// File: rtl/act_quant.sv
// Per-vector absmax activation quantizer: serial absmax scan, restoring
// reciprocal divider, then one rounded, saturated multiply per element.
module act_quant #(
    parameter int ARR_WIDTH = 4,
    parameter int FXP_N     = 16,
    parameter int FXP_R     = 8,
    parameter int Q_BITS    = 8,
    parameter int RECIP_F   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     start,
    input  logic signed [FXP_N-1:0]  input_arr [ARR_WIDTH],
    output logic signed [Q_BITS-1:0] output_q  [ARR_WIDTH],
    output logic        [FXP_N-1:0]  scale_out,
    output logic                     done
);

    localparam int QMAX = 2 ** (Q_BITS - 1) - 1;
    localparam int QW   = Q_BITS - 1 + RECIP_F;
    localparam int PW   = FXP_N + QW + 1;
    localparam int IW   = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
    localparam int CW   = $clog2(QW);

    localparam logic [QW-1:0]        DIVIDEND = QW'(QMAX) << RECIP_F;
    localparam logic signed [PW-1:0] QMAX_P   = PW'(QMAX);
    localparam logic signed [PW-1:0] QMIN_P   = -QMAX_P;
    localparam logic signed [PW-1:0] HALF     = PW'(1) << (RECIP_F - 1);

    if (FXP_R >= FXP_N) begin : g_bad_fmt
        $error("act_quant: FXP_R must be below FXP_N");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAX,
        S_DIV,
        S_QUANT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [FXP_N-1:0]  x_buf [ARR_WIDTH];
    logic signed [Q_BITS-1:0] q_buf [ARR_WIDTH];
    logic [FXP_N-1:0] absmax;
    logic [QW-1:0]    recip;
    logic [QW-1:0]    num;
    logic [FXP_N-1:0] rem;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    div_cnt;

    logic signed [FXP_N-1:0]  x_sel;
    logic [FXP_N-1:0]         x_abs;
    logic [FXP_N-1:0]         absmax_nxt;
    logic                     last_idx;
    logic                     last_div;
    logic [FXP_N:0]           rem_sh;
    logic                     q_bit;
    logic [FXP_N-1:0]         rem_dif;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     q_full;
    logic signed [Q_BITS-1:0] q_sat;

    assign done = (state == S_DONE);

    always_comb begin
        x_sel      = x_buf[idx];
        // Two's-complement negate into an unsigned word keeps |min| exact
        x_abs      = x_sel[FXP_N-1] ? FXP_N'(-x_sel) : FXP_N'(x_sel);
        absmax_nxt = (x_abs > absmax) ? x_abs : absmax;
        last_idx   = (idx == IW'(ARR_WIDTH - 1));
        last_div   = (div_cnt == CW'(QW - 1));
        rem_sh     = {rem, num[QW-1]};
        q_bit      = (rem_sh >= {1'b0, absmax});
        rem_dif    = rem_sh[FXP_N-1:0] - absmax;
        prod       = PW'(x_sel) * PW'($signed({1'b0, recip}));
        q_full     = (prod + HALF) >>> RECIP_F;
        if (q_full > QMAX_P) begin
            q_sat = Q_BITS'(QMAX);
        end else if (q_full < QMIN_P) begin
            q_sat = Q_BITS'(-QMAX);
        end else begin
            q_sat = q_full[Q_BITS-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        if (enable) begin
            unique case (state)
                S_IDLE, S_DONE: if (start) state_nxt = S_MAX;
                S_MAX: begin
                    if (last_idx) begin
                        state_nxt = (absmax_nxt == '0) ? S_QUANT : S_DIV;
                    end
                end
                S_DIV:   if (last_div) state_nxt = S_QUANT;
                S_QUANT: if (last_idx) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < ARR_WIDTH; j++) begin
                x_buf[j]    <= '0;
                q_buf[j]    <= '0;
                output_q[j] <= '0;
            end
            scale_out <= '0;
            absmax    <= '0;
            recip     <= '0;
            num       <= '0;
            rem       <= '0;
            idx       <= '0;
            div_cnt   <= '0;
        end else if (enable) begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x_buf  <= input_arr;
                        absmax <= '0;
                        idx    <= '0;
                    end
                end
                S_MAX: begin
                    absmax <= absmax_nxt;
                    if (last_idx) begin
                        idx     <= '0;
                        div_cnt <= '0;
                        rem     <= '0;
                        num     <= DIVIDEND;
                        recip   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DIV: begin
                    rem     <= q_bit ? rem_dif : rem_sh[FXP_N-1:0];
                    recip   <= {recip[QW-2:0], q_bit};
                    num     <= num << 1;
                    div_cnt <= div_cnt + 1'b1;
                end
                S_QUANT: begin
                    q_buf[idx] <= q_sat;
                    if (last_idx) begin
                        // Publish the whole vector at once on the DONE edge
                        for (int j = 0; j < ARR_WIDTH; j++) begin
                            output_q[j] <= (IW'(j) == idx) ? q_sat : q_buf[j];
                        end
                        scale_out <= absmax;
                        idx       <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_act_quant.sv
// Directed bench for act_quant: vector table plus stall, ignored-start,
// mid-run reset and back-to-back sequences.
module tb_act_quant;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic start;
    logic signed [15:0] input_arr [4];
    logic signed [7:0]  output_q  [4];
    logic [15:0]        scale_out;
    logic               done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x [4];
        int q [4];
        int scale;
        int lat;
    } vec_t;

    vec_t tv [5];

    act_quant dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .input_arr (input_arr),
        .output_q  (output_q),
        .scale_out (scale_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < 4; i++) input_arr[i] = 16'(v.x[i]);
    endtask

    task automatic check_out(input string tag, input vec_t v);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s q[%0d]", tag, i), int'(output_q[i]), v.q[i]);
        end
        chk($sformatf("%s scale", tag), int'(scale_out), v.scale);
    endtask

    // Edge e is the e-th clock edge after the one that samples start.
    task automatic run(input vec_t v, input int off_at, input int off_len,
                       input int poke_at, input vec_t poke_v,
                       output int lat);
        drive(v);
        start  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int e = 1; e <= 100; e++) begin
            enable = !(e >= off_at && e < off_at + off_len);
            start  = (e == poke_at);
            if (e == poke_at) drive(poke_v);
            @(posedge clk); #1;
            start  = 1'b0;
            enable = 1'b1;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        int lat;

        tv[0].x = '{256, 512, 768, 1024};
        tv[0].q = '{32, 64, 95, 127};
        tv[0].scale = 1024;
        tv[0].lat = 31;

        tv[1].x = '{640, -896, 1152, -1408};
        tv[1].q = '{58, -81, 104, -127};
        tv[1].scale = 1408;
        tv[1].lat = 31;

        tv[2].x = '{256, 256, 256, 256};
        tv[2].q = '{127, 127, 127, 127};
        tv[2].scale = 256;
        tv[2].lat = 31;

        tv[3].x = '{0, 0, 0, 0};
        tv[3].q = '{0, 0, 0, 0};
        tv[3].scale = 0;
        tv[3].lat = 8;

        tv[4].x = '{-32768, 0, 0, 0};
        tv[4].q = '{-127, 0, 0, 0};
        tv[4].scale = 32768;
        tv[4].lat = 31;

        rst    = 1'b1;
        enable = 1'b0;
        start  = 1'b0;
        drive(tv[3]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset done", int'(done), 0);
        check_out("reset", tv[3]);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            run(tv[t], 0, 0, 0, tv[3], lat);
            chk($sformatf("vec%0d latency", t), lat, tv[t].lat);
            check_out($sformatf("vec%0d", t), tv[t]);
        end

        // Stall in DIV for 5 edges, stray start in QUANT
        run(tv[0], 10, 5, 33, tv[1], lat);
        chk("stall latency", lat, 36);
        check_out("stall", tv[0]);

        // Reset while scanning in MAX
        drive(tv[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst done", int'(done), 0);
        check_out("midrst", tv[3]);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run(tv[1], 0, 0, 0, tv[3], lat);
        chk("postrst latency", lat, 31);
        check_out("postrst", tv[1]);

        // Back-to-back start from DONE
        drive(tv[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b done low", int'(done), 0);
        check_out("b2b hold0", tv[1]);
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = e;
                break;
            end
            if (e == 20) check_out("b2b hold20", tv[1]);
        end
        chk("b2b latency", lat, 31);
        check_out("b2b", tv[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
